// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: opcodes, instruction field positions and error codes shared by encoder and decoder.
// Revision 1.0
`default_nettype none

package inst_encoder_pkg;

  localparam int INST_W = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MPY  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SHL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_CMP  = 5'd9,
    OP_MOV  = 5'd10,
    OP_BR   = 5'd11,
    OP_HALT = 5'd31
  } opcode_e;

  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 27;
  localparam int IMMFLAG_BIT = 26;
  localparam int SEXT_BIT    = 25;
  localparam int Z_HI        = 20;
  localparam int Z_LO        = 16;
  localparam int PRED_HI     = 19;
  localparam int PRED_LO     = 16;
  localparam int IMM_HI      = 15;
  localparam int IMM_LO      = 0;
  localparam int CC_HI       = 12;
  localparam int CC_LO       = 10;
  localparam int A_HI        = 9;
  localparam int A_LO        = 5;
  localparam int B_HI        = 4;
  localparam int B_LO        = 0;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field handshake from the loader and word-write bus toward instruction RAM.
// Revision 1.0
`default_nettype none

interface inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic                               in_valid;
  logic                               in_ready;
  logic [4:0]                         in_opcode;
  logic [4:0]                         in_z;
  logic [4:0]                         in_a;
  logic [4:0]                         in_b;
  logic [15:0]                        in_imm;
  logic                               in_use_imm;
  logic                               in_sext;
  logic [2:0]                         in_cc;
  logic                               mem_we;
  logic                               mem_ready;
  logic [ADDR_W-1:0]                  mem_addr;
  logic [inst_encoder_pkg::INST_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_opcode, in_z, in_a, in_b, in_imm, in_use_imm, in_sext, in_cc,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_opcode, in_z, in_a, in_b, in_imm, in_use_imm, in_sext, in_cc,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_encoder_pack.sv
// inst_encoder_pack: combinational packing of instruction fields into a decoder-format word.
// Revision 1.0
`default_nettype none

module inst_encoder_pack
  import inst_encoder_pkg::*;
(
  input  logic [4:0]        opcode_i,
  input  logic [4:0]        z_i,
  input  logic [4:0]        a_i,
  input  logic [4:0]        b_i,
  input  logic [15:0]       imm_i,
  input  logic              use_imm_i,
  input  logic              sext_i,
  input  logic [2:0]        cc_i,
  output logic [INST_W-1:0] word_o,
  output logic              illegal_o,
  output logic              range_err_o,
  output logic              is_halt_o
);

  always_comb begin
    word_o      = '0;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    is_halt_o   = 1'b0;
    word_o[OPC_HI:OPC_LO] = opcode_i;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SRL, OP_SRA: begin
        word_o[IMMFLAG_BIT] = use_imm_i;
        word_o[SEXT_BIT]    = use_imm_i & sext_i;
        word_o[Z_HI:Z_LO]   = z_i;
        word_o[A_HI:A_LO]   = a_i;
        word_o[B_HI:B_LO]   = use_imm_i ? imm_i[4:0] : b_i;
        // Signed small imm fits only when bits [15:4] are a pure sign extension.
        if (use_imm_i) begin
          if (sext_i)
            range_err_o = !((imm_i[15:4] == 12'h000) || (imm_i[15:4] == 12'hFFF));
          else
            range_err_o = (imm_i[15:5] != 11'h000);
        end
      end
      OP_CMP: begin
        word_o[Z_HI:Z_LO]   = z_i;
        word_o[CC_HI:CC_LO] = cc_i;
        word_o[A_HI:A_LO]   = a_i;
        word_o[B_HI:B_LO]   = b_i;
      end
      OP_MOV: begin
        word_o[Z_HI:Z_LO]       = z_i;
        word_o[IMM_HI:IMM_LO]   = imm_i;
      end
      OP_BR: begin
        word_o[PRED_HI:PRED_LO] = a_i[3:0];
        word_o[IMM_HI:IMM_LO]   = imm_i;
        range_err_o             = a_i[4];
      end
      OP_HALT: begin
        is_halt_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// inst_encoder: streams packed instruction words into instruction RAM at auto-incrementing addresses.
// Revision 1.0
`default_nettype none

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  inst_encoder_if.slave     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   count_o
);

  state_e              state_q;
  logic                out_valid_q;
  logic                halt_pend_q;
  logic [INST_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic                err_q;
  err_code_e           err_code_q;

  logic [INST_W-1:0]   pack_word;
  logic                pack_illegal;
  logic                pack_range_err;
  logic                pack_is_halt;
  logic                in_fire;
  logic                wr_done;
  logic                last_addr;

  inst_encoder_pack u_pack (
    .opcode_i    (bus.in_opcode),
    .z_i         (bus.in_z),
    .a_i         (bus.in_a),
    .b_i         (bus.in_b),
    .imm_i       (bus.in_imm),
    .use_imm_i   (bus.in_use_imm),
    .sext_i      (bus.in_sext),
    .cc_i        (bus.in_cc),
    .word_o      (pack_word),
    .illegal_o   (pack_illegal),
    .range_err_o (pack_range_err),
    .is_halt_o   (pack_is_halt)
  );

  // A bad field can only be accepted when any held word completes the same cycle,
  // so errors never need a separate pending state.
  assign bus.in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.mem_ready) && !halt_pend_q;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign wr_done      = out_valid_q && bus.mem_ready;
  assign last_addr    = (addr_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      halt_pend_q <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q     <= ST_RUN;
            addr_q      <= base_addr_i;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            out_valid_q <= 1'b0;
            halt_pend_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wr_done) begin
            count_q <= count_q + 1'b1;
            if (!last_addr)
              addr_q <= addr_q + 1'b1;
          end
          if (wr_done && last_addr && !halt_pend_q) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b1;
            err_code_q  <= ERR_OVERFLOW;
            state_q     <= ST_DONE;
          end else if (wr_done && halt_pend_q) begin
            out_valid_q <= 1'b0;
            halt_pend_q <= 1'b0;
            state_q     <= ST_DONE;
          end else if (in_fire && (pack_illegal || pack_range_err)) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b1;
            err_code_q  <= pack_illegal ? ERR_ILLEGAL : ERR_RANGE;
            state_q     <= ST_DONE;
          end else if (in_fire) begin
            out_valid_q <= 1'b1;
            wdata_q     <= pack_word;
            halt_pend_q <= pack_is_halt;
          end else if (wr_done) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = out_valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign count_o       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed-vector self-checking bench for inst_encoder.
// Revision 1.0
`default_nettype none

module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          busy_o, done_o, err_o;
  logic [1:0]    err_code_o;
  logic [AW:0]   count_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];
  int            log_c[$];

  inst_encoder_if #(.ADDR_W(AW)) bus ();

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are steady at the falling edge, so a write seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      log_a.push_back(bus.mem_addr);
      log_d.push_back(bus.mem_wdata);
      log_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] z, input logic [4:0] a,
                       input logic [4:0] b, input logic [15:0] imm, input logic ui,
                       input logic sx, input logic [2:0] cc);
    bus.in_opcode  = op;
    bus.in_z       = z;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_imm     = imm;
    bus.in_use_imm = ui;
    bus.in_sext    = sx;
    bus.in_cc      = cc;
    bus.in_valid   = 1'b1;
  endtask

  task automatic xfer();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    start_i     = 1'b1;
    base_addr_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done_o) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    log_c.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    bus.in_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", {err_o, err_code_o}, 0);
    chk("rst_count", count_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // MOV then HALT
    clear_log();
    pulse_start(10'h010);
    chk("t1_busy", busy_o, 1);
    drive(OP_MOV, 5'd3, 5'd0, 5'd0, 16'h1234, 1'b0, 1'b0, 3'd0);
    xfer();
    chk("t1_latency_we", bus.mem_we, 1);
    chk("t1_latency_data", bus.mem_wdata, 32'h5003_1234);
    drive(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t1_done", done_o, 1);
    chk("t1_count", count_o, 2);
    chk("t1_err", err_o, 0);
    chk("t1_nwr", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("t1_a0", log_a[0], 10'h010);
      chk("t1_d0", log_d[0], 32'h5003_1234);
      chk("t1_a1", log_a[1], 10'h011);
      chk("t1_d1", log_d[1], 32'hF800_0000);
    end
    @(posedge clk);
    #1;

    // ALU signed small immediate: -16 fits, -17 does not
    clear_log();
    pulse_start(10'h020);
    drive(OP_ADD, 5'd1, 5'd2, 5'd0, 16'hFFF0, 1'b1, 1'b1, 3'd0);
    xfer();
    chk("t2_word", bus.mem_wdata, 32'h0601_0050);
    drive(OP_ADD, 5'd1, 5'd2, 5'd0, 16'hFFEF, 1'b1, 1'b1, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t2_err", err_o, 1);
    chk("t2_code", err_code_o, 2);
    chk("t2_count", count_o, 1);
    chk("t2_nwr", log_d.size(), 1);
    if (log_d.size() == 1) chk("t2_d0", log_d[0], 32'h0601_0050);
    @(posedge clk);
    #1;

    // Backpressure: stall 3 cycles, then 4 back-to-back writes plus HALT
    clear_log();
    bus.mem_ready = 1'b0;
    pulse_start(10'h040);
    drive(OP_CMP, 5'd4, 5'd6, 5'd7, 16'h0, 1'b0, 1'b0, 3'd5);
    xfer();
    drive(OP_SUB, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", bus.in_ready, 0);
      chk("t3_stall_we", bus.mem_we, 1);
      chk("t3_stall_data", bus.mem_wdata, 32'h4804_14C7);
      chk("t3_stall_addr", bus.mem_addr, 10'h040);
    end
    @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    xfer();
    drive(OP_XOR, 5'd7, 5'd1, 5'd0, 16'h001F, 1'b1, 1'b0, 3'd0);
    xfer();
    drive(OP_MOV, 5'd31, 5'd0, 5'd0, 16'hFFFF, 1'b0, 1'b0, 3'd0);
    xfer();
    drive(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t3_count", count_o, 5);
    chk("t3_nwr", log_d.size(), 5);
    if (log_d.size() == 5) begin
      chk("t3_d0", log_d[0], 32'h4804_14C7);
      chk("t3_d1", log_d[1], 32'h0802_0064);
      chk("t3_d2", log_d[2], 32'h2C07_003F);
      chk("t3_d3", log_d[3], 32'h501F_FFFF);
      chk("t3_d4", log_d[4], 32'hF800_0000);
      chk("t3_a4", log_a[4], 10'h044);
      for (int i = 1; i < 5; i++) chk("t3_b2b", log_c[i] - log_c[i-1], 1);
    end
    @(posedge clk);
    #1;

    // BR predicate in range, then out of range
    clear_log();
    pulse_start(10'h060);
    drive(OP_BR, 5'd0, 5'd5, 5'd0, 16'h0040, 1'b0, 1'b0, 3'd0);
    xfer();
    chk("t4_word", bus.mem_wdata, 32'h5805_0040);
    drive(OP_BR, 5'd0, 5'd17, 5'd0, 16'h0040, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t4_code", err_code_o, 2);
    chk("t4_nwr", log_d.size(), 1);
    @(posedge clk);
    #1;

    // Illegal opcode
    clear_log();
    pulse_start(10'h080);
    drive(5'd20, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t5_code", err_code_o, 1);
    chk("t5_count", count_o, 0);
    chk("t5_nwr", log_d.size(), 0);
    @(posedge clk);
    #1;

    // Address exhaustion at the last word
    clear_log();
    pulse_start(10'h3FF);
    drive(OP_MOV, 5'd1, 5'd0, 5'd0, 16'h0001, 1'b0, 1'b0, 3'd0);
    xfer();
    drive(OP_MOV, 5'd2, 5'd0, 5'd0, 16'h0002, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t6_code", err_code_o, 3);
    chk("t6_count", count_o, 1);
    chk("t6_nwr", log_d.size(), 1);
    if (log_d.size() == 1) begin
      chk("t6_a0", log_a[0], 10'h3FF);
      chk("t6_d0", log_d[0], 32'h5001_0001);
    end
    @(negedge clk);
    chk("t6_we_after", bus.mem_we, 0);
    @(posedge clk);
    #1;

    // Reset with a word held on the bus, then a normal run ignoring a second start
    clear_log();
    bus.mem_ready = 1'b0;
    pulse_start(10'h0A0);
    drive(OP_MOV, 5'd1, 5'd0, 5'd0, 16'h0007, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    chk("t7_we_held", bus.mem_we, 1);
    #3 rst = 1'b1;
    #1;
    chk("t7_rst_we", bus.mem_we, 0);
    chk("t7_rst_addr", bus.mem_addr, 0);
    chk("t7_rst_data", bus.mem_wdata, 0);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_count", count_o, 0);
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t7_no_wr", log_d.size(), 0);
    pulse_start(10'h005);
    pulse_start(10'h009);
    drive(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    xfer();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t7_count", count_o, 1);
    chk("t7_err", err_o, 0);
    chk("t7_nwr", log_d.size(), 1);
    if (log_d.size() == 1) begin
      chk("t7_a0", log_a[0], 10'h005);
      chk("t7_d0", log_d[0], 32'hF800_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
